// File: rtl/pixel_alu_pkg.sv
// Shared definitions for the pixel ALU path: opcode values, pixel width,
// modulus used by the add/sub transforms, and the inverse engine FSM encoding.
package pixel_alu_pkg;

  localparam int PIX_W   = 8;
  localparam int MOD_VAL = 255;

  // Opcode values must match the forward ALU bit-for-bit.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_ROTR = 3'd6;
  localparam logic [2:0] OP_ROTL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic op_is_lossy(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/pixel_inv_alu.sv
// Combinational single-step inverse of the forward pixel ALU: given an opcode,
// an encoded value y and the key k, returns the recovered value x.
module pixel_inv_alu
  import pixel_alu_pkg::*;
(
  input  logic [2:0]       i_op,
  input  logic [PIX_W-1:0] i_y,
  input  logic [PIX_W-1:0] i_k,
  output logic [PIX_W-1:0] o_x,
  output logic             o_lossy
);

  logic [2:0]       w_amt;
  logic [3:0]       w_amtInv;
  logic [PIX_W-1:0] w_rotLeft;
  logic [PIX_W-1:0] w_rotRight;
  logic [PIX_W-1:0] w_addInv;
  logic [PIX_W:0]   w_subSum;

  // A shift of 8 yields zero, so amount 0 naturally collapses to identity.
  always_comb begin
    w_amt      = i_k[2:0];
    w_amtInv   = 4'd8 - {1'b0, w_amt};
    w_rotLeft  = (i_y << w_amt) | (i_y >> w_amtInv);
    w_rotRight = (i_y >> w_amt) | (i_y << w_amtInv);
    w_addInv   = (i_y < i_k) ? PIX_W'({1'b0, i_y} + (PIX_W+1)'(MOD_VAL) - {1'b0, i_k})
                             : PIX_W'({1'b0, i_y} - {1'b0, i_k});
    w_subSum   = {1'b0, i_y} + {1'b0, i_k};

    o_x = i_y;
    unique case (i_op)
      OP_ADD:  o_x = w_addInv;
      OP_SUB:  o_x = (w_subSum > (PIX_W+1)'(MOD_VAL)) ? PIX_W'(w_subSum - (PIX_W+1)'(MOD_VAL))
                                                      : w_subSum[PIX_W-1:0];
      OP_XOR:  o_x = i_y ^ i_k;
      OP_ROTR: o_x = w_rotLeft;
      OP_ROTL: o_x = w_rotRight;
      default: o_x = i_y;
    endcase
    o_lossy = op_is_lossy(i_op);
  end

endmodule

// File: rtl/pixel_inverse_engine.sv
// Streaming decoder that replays the stored forward program backwards, one
// inverse op per clock. Define PIXEL_INVERSE_ERR_CNT_EN to build the lossy-pixel counter.
module pixel_inverse_engine
  import pixel_alu_pkg::*;
#(
  parameter int MAX_OPS = 8,
  parameter int IDX_W   = $clog2(MAX_OPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [2:0]       cfg_op,
  input  logic [7:0]       cfg_operand,
  input  logic [IDX_W:0]   cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pixel,
  output logic             out_lossy,
  output logic             busy,
  output logic [15:0]      err_count
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_OPS);

  logic [2:0]       r_tblOp  [MAX_OPS];
  logic [7:0]       r_tblKey [MAX_OPS];
  logic [IDX_W:0]   r_len;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_acc;
  logic             r_lossy;
  state_t           r_state;
  state_t           w_nextState;

  logic             w_cfgAccept;
  logic [IDX_W:0]   w_cfgLenSat;
  logic [7:0]       w_aluX;
  logic             w_aluLossy;

  // Programming is only safe while no pixel is in flight or being offered.
  assign w_cfgAccept = cfg_we && (r_state == ST_IDLE) && !in_valid;
  assign w_cfgLenSat = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  always_ff @(posedge clk) begin
    if (!reset && w_cfgAccept) begin
      r_tblOp[cfg_addr]  <= cfg_op;
      r_tblKey[cfg_addr] <= cfg_operand;
    end
  end

  pixel_inv_alu u_alu (
    .i_op    (r_tblOp[r_idx]),
    .i_y     (r_acc),
    .i_k     (r_tblKey[r_idx]),
    .o_x     (w_aluX),
    .o_lossy (w_aluLossy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_pixel   = '0;
    out_lossy   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_nextState = (r_len == '0) ? ST_HOLD : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_idx == '0) begin
          w_nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        out_pixel = r_acc;
        out_lossy = r_lossy;
        if (out_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Last program entry is undone first, walking the index down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_lossy <= 1'b0;
    end else begin
      if (w_cfgAccept) begin
        r_len <= w_cfgLenSat;
      end
      if (r_state == ST_IDLE && in_valid) begin
        r_acc   <= in_pixel;
        r_idx   <= IDX_W'(r_len - 1'b1);
        r_lossy <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_acc   <= w_aluX;
        r_lossy <= r_lossy | w_aluLossy;
        if (r_idx != '0) begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end

`ifdef PIXEL_INVERSE_ERR_CNT_EN
  logic [15:0] r_errCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_errCount <= '0;
    end else if (out_valid && out_ready && out_lossy && (r_errCount != 16'hFFFF)) begin
      r_errCount <= r_errCount + 16'd1;
    end
  end

  assign err_count = r_errCount;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_pixel_inverse_engine.sv
// Scoreboard bench for pixel_inverse_engine: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every output handshake.
module tb_pixel_inverse_engine;

  localparam logic [2:0] T_ADD  = 3'd1;
  localparam logic [2:0] T_SUB  = 3'd2;
  localparam logic [2:0] T_XOR  = 3'd3;
  localparam logic [2:0] T_SHL  = 3'd5;
  localparam logic [2:0] T_ROTR = 3'd6;
  localparam logic [2:0] T_ROTL = 3'd7;

  typedef struct {
    logic [7:0] pix;
    logic       lossy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [2:0]  cfg_op;
  logic [7:0]  cfg_operand;
  logic [3:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic        out_lossy;
  logic        busy;
  logic [15:0] err_count;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          expErr = 0;

  pixel_inverse_engine #(.MAX_OPS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_op      (cfg_op),
    .cfg_operand (cfg_operand),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_lossy   (out_lossy),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: the handshake completes at the next posedge whenever both are high here.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected output: got %h, expected none", out_pixel);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_pixel", {8'h00, out_pixel}, {8'h00, e.pix});
        checkOutput("out_lossy", {15'h0, out_lossy}, {15'h0, e.lossy});
      end
    end
  end

  task automatic writeEntry(input logic [2:0] addr, input logic [2:0] op,
                            input logic [7:0] key, input logic [3:0] len);
    cfg_we      = 1'b1;
    cfg_addr    = addr;
    cfg_op      = op;
    cfg_operand = key;
    cfg_len     = len;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] pix, input logic [7:0] expPix,
                               input logic expLossy, input bit track);
    exp_t e;
    bit   done;
    e.pix   = expPix;
    e.lossy = expLossy;
    if (track) expQ.push_back(e);
    in_valid = 1'b1;
    in_pixel = pix;
    done     = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL input accept timeout: got in_ready 0, expected 1");
    end
  endtask

  task automatic measureLatency(input int expLat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    checkOutput("latency", 16'(lat), 16'(expLat));
  endtask

  task automatic waitDrain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !out_valid) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got %0d pending, expected 0", expQ.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_op = '0; cfg_operand = '0;
    cfg_len = '0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", {15'h0, in_ready}, 16'h1);
    checkOutput("reset out_valid", {15'h0, out_valid}, 16'h0);
    checkOutput("reset out_pixel", {8'h0, out_pixel}, 16'h0);
    checkOutput("reset out_lossy", {15'h0, out_lossy}, 16'h0);
    checkOutput("reset busy", {15'h0, busy}, 16'h0);
    checkOutput("reset err_count", err_count, 16'h0);
    @(posedge clk); #1;

    // Empty program passes the pixel straight through.
    applyStimulus(8'hA5, 8'hA5, 1'b0, 1);
    measureLatency(1);
    waitDrain();

    // Forward add 10, xor 3C, rotl 3 maps 52 -> 62 -> 5E -> F2.
    writeEntry(3'd0, T_ADD, 8'h10, 4'd3);
    writeEntry(3'd1, T_XOR, 8'h3C, 4'd3);
    writeEntry(3'd2, T_ROTL, 8'h03, 4'd3);
    applyStimulus(8'hF2, 8'h52, 1'b0, 1);
    measureLatency(4);
    waitDrain();
    applyStimulus(8'hE7, 8'hB0, 1'b0, 1);
    waitDrain();

    writeEntry(3'd0, T_ADD, 8'h01, 4'd1);
    applyStimulus(8'h01, 8'h00, 1'b0, 1);
    applyStimulus(8'h00, 8'hFE, 1'b0, 1);
    waitDrain();

    writeEntry(3'd0, T_SUB, 8'h05, 4'd1);
    applyStimulus(8'hFD, 8'h03, 1'b0, 1);
    applyStimulus(8'hFE, 8'h04, 1'b0, 1);
    applyStimulus(8'hFA, 8'hFF, 1'b0, 1);
    waitDrain();

    writeEntry(3'd0, T_ROTR, 8'h01, 4'd1);
    applyStimulus(8'hC0, 8'h81, 1'b0, 1);
    waitDrain();

    writeEntry(3'd0, T_SHL, 8'h02, 4'd1);
    checkOutput("err_count before lossy", err_count, 16'(expErr));
    applyStimulus(8'h44, 8'h44, 1'b1, 1);
`ifdef PIXEL_INVERSE_ERR_CNT_EN
    expErr = expErr + 1;
`endif
    waitDrain();
    checkOutput("err_count after lossy", err_count, 16'(expErr));

    // Stalled output must hold steady and block new input.
    writeEntry(3'd0, T_XOR, 8'hFF, 4'd1);
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'hED, 1'b0, 1);
    measureLatency(2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall out_pixel", {8'h0, out_pixel}, 16'h00ED);
      checkOutput("stall in_ready", {15'h0, in_ready}, 16'h0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitDrain();

    // A write while running must leave both table and length untouched.
    writeEntry(3'd0, T_XOR, 8'h01, 4'd4);
    writeEntry(3'd1, T_XOR, 8'h02, 4'd4);
    writeEntry(3'd2, T_XOR, 8'h04, 4'd4);
    writeEntry(3'd3, T_XOR, 8'h08, 4'd4);
    applyStimulus(8'h50, 8'h5F, 1'b0, 1);
    writeEntry(3'd0, T_XOR, 8'hF0, 4'd1);
    waitDrain();
    applyStimulus(8'hAA, 8'hA5, 1'b0, 1);
    waitDrain();

    // Length above the table depth saturates to the full eight entries.
    for (int i = 0; i < 8; i++) begin
      writeEntry(3'(i), T_XOR, 8'(1 << i), 4'd15);
    end
    applyStimulus(8'h0F, 8'hF0, 1'b0, 1);
    measureLatency(9);
    waitDrain();

    // Reset mid-run drops the pixel and clears the program length.
    applyStimulus(8'h33, 8'h00, 1'b0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expErr = 0;
    @(negedge clk);
    checkOutput("abort out_valid", {15'h0, out_valid}, 16'h0);
    checkOutput("abort busy", {15'h0, busy}, 16'h0);
    checkOutput("abort in_ready", {15'h0, in_ready}, 16'h1);
    checkOutput("abort err_count", err_count, 16'(expErr));
    @(posedge clk); #1;
    applyStimulus(8'h37, 8'h37, 1'b0, 1);
    measureLatency(1);
    waitDrain();

    checkOutput("scoreboard empty", 16'(expQ.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
